// File: rtl/ula_bcd_display.sv
// ula_bcd_display: signed-magnitude add/subtract with registered result and 3-digit active-low 7-segment readout
module ula_bcd_display #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic       enable,
  output logic [8:0] r,
  output logic [6:0] seg_u,
  output logic [6:0] seg_t,
  output logic [6:0] seg_h,
  output logic       sign_n
);
  logic signed [8:0] sa, sb, v;
  logic [7:0] mag;
  logic [3:0] dig_u, dig_t, dig_h;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0000001;
      4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;
      4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;
      4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;
      4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // 9-bit signed covers -254..+254, so the sum never overflows
  always_comb begin
    sa  = a[7] ? -$signed({2'b00, a[6:0]}) : $signed({2'b00, a[6:0]});
    sb  = b[7] ? -$signed({2'b00, b[6:0]}) : $signed({2'b00, b[6:0]});
    v   = (op == OP_SUB) ? sa - sb : sa + sb;
    mag = v[8] ? 8'(-v) : v[7:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (op == OP_ADD || op == OP_SUB) r <= {v[8], mag};

  always_comb begin
    dig_h  = 4'(r[7:0] / 8'd100);
    dig_t  = 4'((r[7:0] / 8'd10) % 8'd10);
    dig_u  = 4'(r[7:0] % 8'd10);
    seg_h  = enable ? seg7(dig_h) : 7'b1111111;
    seg_t  = enable ? seg7(dig_t) : 7'b1111111;
    seg_u  = enable ? seg7(dig_u) : 7'b1111111;
    sign_n = ~r[8];
  end
endmodule

// File: tb/tb_ula_bcd_display.sv
// tb_ula_bcd_display: scoreboard bench for ula_bcd_display
module tb_ula_bcd_display;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] a = 0, b = 0;
  logic [2:0] op = 0;
  logic       enable = 1;
  logic [8:0] r;
  logic [6:0] seg_u, seg_t, seg_h;
  logic       sign_n;

  int checks = 0, failures = 0;
  logic [8:0] sbq[$];
  logic [8:0] exp_prev = 0;
  logic [6:0] enc [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  ula_bcd_display dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .enable(enable),
                       .r(r), .seg_u(seg_u), .seg_t(seg_t), .seg_h(seg_h), .sign_n(sign_n));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [2:0] o, input logic [8:0] prev);
    int sa, sb, v;
    sa = x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    sb = y[7] ? -int'(y[6:0]) : int'(y[6:0]);
    if (o > 3'd1) return prev;
    v = (o == 3'd0) ? sa + sb : sa - sb;
    return {v < 0, 8'(v < 0 ? -v : v)};
  endfunction

  task automatic chk_disp(input logic [8:0] e);
    int m;
    m = int'(e[7:0]);
    chk("sign_n", 32'(sign_n), 32'(!e[8]));
    chk("seg_h", 32'(seg_h), 32'(enable ? enc[m / 100] : 7'h7f));
    chk("seg_t", 32'(seg_t), 32'(enable ? enc[(m / 10) % 10] : 7'h7f));
    chk("seg_u", 32'(seg_u), 32'(enable ? enc[m % 10] : 7'h7f));
  endtask

  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    logic [8:0] e;
    a = x; b = y; op = o;
    exp_prev = model(x, y, o, exp_prev);
    sbq.push_back(exp_prev);
    @(posedge clk); #1;
    if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sbq.pop_front();
      chk("r", 32'(r), 32'(e));
      chk_disp(e);
    end
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_r", 32'(r), 32'd0);
    chk_disp(9'd0);
    @(negedge clk); rst_n = 1;
    step(8'd25, 8'd17, 3'd0);
    chk("add_r", 32'(r), 32'd42);
    chk("add_u", 32'(seg_u), 32'(7'b0010010));
    chk("add_t", 32'(seg_t), 32'(7'b1001100));
    chk("add_h", 32'(seg_h), 32'(7'b0000001));
    step(8'd12, 8'd30, 3'd1);
    chk("sub_neg", 32'(r), 32'h112);
    chk("sub_neg_sign", 32'(sign_n), 32'd0);
    step(8'd30, 8'd30, 3'd1);
    chk("sub_zero", 32'(r), 32'd0);
    step(8'h80 | 8'd99, 8'd99, 3'd1);
    chk("sm_sub", 32'(r), 32'h1C6);
    step(8'h85, 8'd7, 3'd0);
    chk("sm_add", 32'(r), 32'd2);
    step(8'h80, 8'h00, 3'd1);
    chk("neg_zero", 32'(r), 32'd0);
    enable = 0;
    step(8'd50, 8'd77, 3'd0);
    step(8'hFF, 8'hFF, 3'd0);
    chk("dis_r", 32'(r), 32'h1FE);
    enable = 1;
    step(8'd9, 8'd1, 3'd0);
    for (int i = 0; i < 5; i++) step(8'($urandom), 8'($urandom), 3'b101);
    chk("illegal_hold", 32'(r), 32'd10);
    for (int i = 0; i < 20; i++) begin
      enable = 1'($urandom_range(0, 3) != 0);
      step(8'($urandom), 8'($urandom), 3'($urandom_range(0, 2)));
    end
    enable = 1;
    step(8'd100, 8'd100, 3'd0);
    chk("pre_rst", 32'(r), 32'h0C8);
    #2 rst_n = 0;
    #1;
    chk("async_rst", 32'(r), 32'd0);
    chk_disp(9'd0);
    exp_prev = 0;
    sbq.delete();
    @(posedge clk); #1;
    chk("rst_hold", 32'(r), 32'd0);
    @(negedge clk); rst_n = 1;
    step(8'd1, 8'd2, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ula_bcd_display.md
Name: ula_bcd_display

Overview:
- Signed-magnitude add/subtract unit with a registered 9-bit result.
- Drives three active-low 7-segment digits (units, tens, hundreds) and a sign indicator.
- Sits between the remote-control command FSM, which supplies operands A/B, the operation code and the display enable, and the board's HEX displays and sign LED.
- Merges the existing ula (arithmetic) and bcdout (display decode) functions into one clocked block.

Parameters:
- OP_ADD, 3'b000, op code for A+B.
- OP_SUB, 3'b001, op code for A-B.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  8  operand A, signed-magnitude: bit7 = sign (1 = negative), bits6:0 = magnitude.
- b  input  8  operand B, same format as a.
- op  input  3  operation select.
- enable  input  1  display enable; 0 blanks all digits.
- r  output  9  registered result, signed-magnitude: bit8 = sign, bits7:0 = magnitude.
- seg_u  output  7  units digit of |r|, active-low, bit order abcdefg (a = MSB).
- seg_t  output  7  tens digit of |r|.
- seg_h  output  7  hundreds digit of |r|.
- sign_n  output  1  ~r[8]; low when the result is negative.

Behaviour:
- Reset:
  - rst_n low asynchronously clears r to 9'd0.
  - Segment outputs follow from r and enable: digits show "000" if enable=1, blank if enable=0. sign_n = 1.
  - Reset mid-operation discards any pending result.
- Arithmetic:
  - Each rising clk with rst_n high computes the result from the current a, b, op.
  - The result is registered into r one cycle after the inputs.
  - Signed values: SA = (a[7] ? -a[6:0] : a[6:0]), SB likewise.
  - OP_ADD: V = SA + SB. OP_SUB: V = SA - SB.
  - Range is -254..+254; no overflow is possible.
  - r[7:0] = |V|; r[8] = 1 iff V < 0.
  - Zero is always positive: r[8] = 0 when |V| = 0.
  - op values 2..7: r holds its previous value.
- Display:
  - Combinational from r and enable.
  - Hundreds = |r| / 100, tens = (|r| / 10) % 10, units = |r| % 10.
  - No leading-zero suppression.
- Segment codes, active-low abcdefg:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Any other value = 1111111.
- enable = 0 forces seg_u/seg_t/seg_h = 1111111. enable does not affect r or sign_n.
- sign_n is combinational from r[8] and is independent of enable.
- Inputs changing every cycle:
  - r tracks with exactly one cycle of latency; no hold or handshake.
  - op and operands are sampled on the same edge.

Test Plan:
- Reset: assert rst_n=0 mid-run with r=9'h0C8 -> r=0 immediately. With enable=1, segs show 0,0,0 (0000001 ×3) and sign_n=1.
- Add positive operands: a=8'd25, b=8'd17, op=0, enable=1 -> next cycle r=9'd42. seg_u=0010010, seg_t=1001100, seg_h=0000001, sign_n=1.
- Subtract, negative result: a=8'd12, b=8'd30, op=1 -> r = {1, 8'd18}, sign_n=0, digits 0,1,8. Also a=8'd30, b=8'd30, op=1 -> r=0 with r[8]=0.
- Signed-magnitude operands: a=8'h80|8'd99 (-99), b=8'd99, op=1 -> r = {1, 8'd198}, digits 1,9,8. Also a=-5, b=+7, op=0 -> r=+2.
- Enable and illegal op: enable=0 -> all segs 1111111 while r keeps updating. op=3'b101 -> r unchanged across 5 cycles despite changing a/b.
- Back-to-back: change a/b/op every cycle for 20 random cycles -> each r equals the model of the inputs from the previous cycle.
